obstacle_field: RTL and testbench

- Parametrised successor to the single-obstacle controller. Manages NUM_OBS falling obstacle slots, an LFSR-driven spawner, speed ramping, per-slot AABB collision against the player, score, and an IDLE/RUN/OVER game FSM.
- Sits between game_clock_generator (game_en tick) and player_control (player_x) upstream, and the renderer downstream (flattened slot positions and active mask).

---
 rtl/game_pkg.sv | 16 +
 rtl/obstacle_slot.sv | 60 ++++++
 rtl/obstacle_field.sv | 168 ++++++++++++++++
 tb/tb_obstacle_field.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared screen constants, game state encoding and LFSR taps for the obstacle field.
package game_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  // Galois taps 16,14,13,11 for a right-shifting 16-bit LFSR
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_t;

endpackage

// File: rtl/obstacle_slot.sv
// One falling obstacle: position/active state, fall step, retirement pulse and player AABB hit.
// retire and hit are combinational from the slot registers so the top can count and register them.
module obstacle_slot #(
  parameter int OBS_W    = 40,
  parameter int OBS_H    = 40,
  parameter int PLAYER_W = 30,
  parameter int PLAYER_H = 30,
  parameter int PLAYER_Y = 315,
  parameter int SCREEN_H = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       tick,
  input  logic       spawn,
  input  logic [9:0] spawn_x,
  input  logic [4:0] speed,
  input  logic [9:0] player_x,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       active,
  output logic       retire,
  output logic       hit
);
  import game_pkg::*;

  logic [10:0] y_next;

  assign y_next = {1'b0, y} + {6'd0, speed};
  assign retire = tick & active & (y_next >= 11'(SCREEN_H));

  // All sums held in 11 bits so edge-of-screen positions cannot wrap
  always_comb begin
    hit = active
       && ({1'b0, x} < ({1'b0, player_x} + 11'(PLAYER_W)))
       && ({1'b0, player_x} < ({1'b0, x} + 11'(OBS_W)))
       && ({1'b0, y} < 11'(PLAYER_Y + PLAYER_H))
       && (11'(PLAYER_Y) < ({1'b0, y} + 11'(OBS_H)));
  end

  // spawn is only offered to a slot that is inactive, so it never meets retire
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      x      <= '0;
      y      <= '0;
      active <= 1'b0;
    end else if (tick) begin
      if (spawn) begin
        active <= 1'b1;
        x      <= spawn_x;
        y      <= '0;
      end else if (retire) begin
        active <= 1'b0;
      end else if (active) begin
        y <= y_next[9:0];
      end
    end
  end

endmodule

// File: rtl/obstacle_field.sv
// Obstacle field controller: game FSM, LFSR spawner, speed ramp, score and collision over NUM_OBS slots.
// All outputs registered; a game_en tick is visible one clk later.
module obstacle_field #(
  parameter int          NUM_OBS      = 4,
  parameter int          OBS_W        = 40,
  parameter int          OBS_H        = 40,
  parameter int          PLAYER_W     = 30,
  parameter int          PLAYER_H     = 30,
  parameter int          PLAYER_Y     = 315,
  parameter int          SCREEN_W     = game_pkg::SCREEN_W,
  parameter int          SCREEN_H     = game_pkg::SCREEN_H,
  parameter int          BASE_SPEED   = 4,
  parameter int          SPEED_STEP   = 2,
  parameter int          MAX_SPEED    = 16,
  parameter int          LEVEL_PASSES = 8,
  parameter int          SPAWN_GAP    = 30,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  game_en,
  input  logic                  start,
  input  logic [9:0]            player_x,
  output logic [NUM_OBS*10-1:0] obs_x,
  output logic [NUM_OBS*10-1:0] obs_y,
  output logic [NUM_OBS-1:0]    obs_active,
  output logic                  collision,
  output logic                  game_over,
  output logic [4:0]            speed,
  output logic [15:0]           score
);
  import game_pkg::*;

  localparam logic [15:0] GAP_LAST = 16'(SPAWN_GAP - 1);
  localparam logic [9:0]  X_RANGE  = 10'(SCREEN_W - OBS_W);

  state_t              state;
  logic [15:0]         lfsr;
  logic [15:0]         spawn_cnt;
  logic [7:0]          pass_cnt;

  logic                tick;
  logic                slot_clear;
  logic                spawn_due;
  logic                has_free;
  logic [NUM_OBS-1:0]  lowest_free;
  logic [NUM_OBS-1:0]  spawn_vec;
  logic [NUM_OBS-1:0]  retire;
  logic [NUM_OBS-1:0]  hit;
  logic [3:0]          n_retire;
  logic [7:0]          pass_sum;
  logic [16:0]         score_sum;
  logic [15:0]         score_next;
  logic [5:0]          speed_up;
  logic [4:0]          speed_next;
  logic [15:0]         lfsr_next;
  logic [9:0]          spawn_x;

  assign tick       = game_en && (state == RUN) && !collision;
  assign slot_clear = start && (state != RUN);
  assign spawn_due  = tick && (spawn_cnt == GAP_LAST);
  assign has_free   = ~&obs_active;

  // Last assignment wins, so iterating downward leaves the lowest free index
  always_comb begin
    lowest_free = '0;
    for (int i = NUM_OBS - 1; i >= 0; i--) begin
      if (!obs_active[i]) lowest_free = NUM_OBS'(1) << i;
    end
  end

  assign spawn_vec = spawn_due ? lowest_free : '0;

  always_comb begin
    n_retire = '0;
    for (int i = 0; i < NUM_OBS; i++) begin
      n_retire = n_retire + 4'(retire[i]);
    end
  end

  assign pass_sum   = pass_cnt + 8'(n_retire);
  assign score_sum  = {1'b0, score} + 17'(n_retire);
  assign score_next = score_sum[16] ? 16'hFFFF : score_sum[15:0];
  assign speed_up   = {1'b0, speed} + 6'(SPEED_STEP);
  assign speed_next = (speed_up > 6'(MAX_SPEED)) ? 5'(MAX_SPEED) : speed_up[4:0];
  assign lfsr_next  = lfsr[0] ? ({1'b0, lfsr[15:1]} ^ LFSR_MASK) : {1'b0, lfsr[15:1]};
  assign spawn_x    = (lfsr[9:0] >= X_RANGE) ? (lfsr[9:0] - X_RANGE) : lfsr[9:0];

  for (genvar g = 0; g < NUM_OBS; g++) begin : g_slot
    obstacle_slot #(
      .OBS_W   (OBS_W),
      .OBS_H   (OBS_H),
      .PLAYER_W(PLAYER_W),
      .PLAYER_H(PLAYER_H),
      .PLAYER_Y(PLAYER_Y),
      .SCREEN_H(SCREEN_H)
    ) u_slot (
      .clk     (clk),
      .rst     (rst),
      .clear   (slot_clear),
      .tick    (tick),
      .spawn   (spawn_vec[g]),
      .spawn_x (spawn_x),
      .speed   (speed),
      .player_x(player_x),
      .x       (obs_x[g*10 +: 10]),
      .y       (obs_y[g*10 +: 10]),
      .active  (obs_active[g]),
      .retire  (retire[g]),
      .hit     (hit[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lfsr      <= LFSR_SEED;
      spawn_cnt <= '0;
      pass_cnt  <= '0;
      speed     <= 5'(BASE_SPEED);
      score     <= '0;
      collision <= 1'b0;
      game_over <= 1'b0;
    end else begin
      case (state)
        IDLE, OVER: begin
          if (state == IDLE) collision <= 1'b0;
          // A new game keeps the LFSR running so successive games differ
          if (start) begin
            state     <= RUN;
            game_over <= 1'b0;
            spawn_cnt <= '0;
            pass_cnt  <= '0;
            speed     <= 5'(BASE_SPEED);
            score     <= '0;
            collision <= 1'b0;
          end
        end
        RUN: begin
          if (collision) begin
            state     <= OVER;
            game_over <= 1'b1;
          end else begin
            collision <= |hit;
            if (game_en) begin
              score <= score_next;
              if (pass_sum >= 8'(LEVEL_PASSES)) begin
                pass_cnt <= '0;
                speed    <= speed_next;
              end else begin
                pass_cnt <= pass_sum;
              end
              // With every slot busy the spawner waits armed at the last count
              if (spawn_cnt == GAP_LAST) begin
                if (has_free) spawn_cnt <= '0;
              end else begin
                spawn_cnt <= spawn_cnt + 16'd1;
              end
              lfsr <= lfsr_next;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_obstacle_field.sv
// Randomised scoreboard bench for obstacle_field against a slot-array reference model.
module tb_obstacle_field;

  localparam int NO = 4, OW = 40, OH = 40, PW = 30, PH = 30, PY = 315;
  localparam int SW = 640, SH = 480, BS = 4, SS = 2, MS = 16, LP = 2, GAP = 3;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam int NCYC = 12000;

  logic            clk = 1'b0;
  logic            rst, game_en, start;
  logic [9:0]      player_x;
  logic [NO*10-1:0] obs_x, obs_y;
  logic [NO-1:0]   obs_active;
  logic            collision, game_over;
  logic [4:0]      speed;
  logic [15:0]     score;

  always #5 clk = ~clk;

  obstacle_field #(
    .NUM_OBS(NO), .OBS_W(OW), .OBS_H(OH), .PLAYER_W(PW), .PLAYER_H(PH), .PLAYER_Y(PY),
    .SCREEN_W(SW), .SCREEN_H(SH), .BASE_SPEED(BS), .SPEED_STEP(SS), .MAX_SPEED(MS),
    .LEVEL_PASSES(LP), .SPAWN_GAP(GAP), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .rst(rst), .game_en(game_en), .start(start), .player_x(player_x),
    .obs_x(obs_x), .obs_y(obs_y), .obs_active(obs_active), .collision(collision),
    .game_over(game_over), .speed(speed), .score(score)
  );

  typedef struct {
    logic [NO*10-1:0] x;
    logic [NO*10-1:0] y;
    logic [NO-1:0]    act;
    logic             coll;
    logic             over;
    logic [4:0]       spd;
    logic [15:0]      sc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int fails  = 0;

  // Reference model: 0 idle, 1 running, 2 game over
  int mx[NO], my[NO];
  bit ma[NO];
  int mstate, mscore, mspeed, mpass, mspawn, mlfsr;
  bit mcoll;

  task automatic new_game();
    for (int i = 0; i < NO; i++) begin
      mx[i] = 0; my[i] = 0; ma[i] = 0;
    end
    mscore = 0; mspeed = BS; mpass = 0; mspawn = 0; mcoll = 0;
  endtask

  task automatic model_reset();
    new_game();
    mstate = 0;
    mlfsr  = SEED;
  endtask

  function automatic bit any_hit(int px);
    bit h = 0;
    for (int i = 0; i < NO; i++) begin
      if (ma[i] && mx[i] < px + PW && px < mx[i] + OW && my[i] < PY + PH && PY < my[i] + OH)
        h = 1;
    end
    return h;
  endfunction

  task automatic game_tick();
    int first_free = -1;
    int retired = 0;
    for (int i = 0; i < NO; i++)
      if (!ma[i] && first_free < 0) first_free = i;
    for (int i = 0; i < NO; i++) begin
      if (ma[i]) begin
        if (my[i] + mspeed >= SH) begin
          ma[i] = 0;
          retired++;
        end else begin
          my[i] += mspeed;
        end
      end
    end
    mscore = (mscore + retired > 65535) ? 65535 : mscore + retired;
    mpass += retired;
    if (mpass >= LP) begin
      mpass  = 0;
      mspeed = (mspeed + SS > MS) ? MS : mspeed + SS;
    end
    if (mspawn == GAP - 1) begin
      if (first_free >= 0) begin
        ma[first_free] = 1;
        my[first_free] = 0;
        mx[first_free] = (mlfsr % 1024 >= SW - OW) ? (mlfsr % 1024) - (SW - OW) : mlfsr % 1024;
        mspawn = 0;
      end
    end else begin
      mspawn++;
    end
    mlfsr = (mlfsr % 2 == 1) ? ((mlfsr / 2) ^ 'hB400) : (mlfsr / 2);
  endtask

  task automatic model_step(bit r, bit ge, bit st, int px);
    bit nc;
    if (r) begin
      model_reset();
    end else if (mstate == 1) begin
      if (mcoll) begin
        mstate = 2;
      end else begin
        nc = any_hit(px);
        if (ge) game_tick();
        mcoll = nc;
      end
    end else if (st) begin
      new_game();
      mstate = 1;
    end
  endtask

  function automatic exp_t snap();
    exp_t e;
    for (int i = 0; i < NO; i++) begin
      e.x[i*10 +: 10] = 10'(mx[i]);
      e.y[i*10 +: 10] = 10'(my[i]);
      e.act[i]        = ma[i];
    end
    e.coll = mcoll;
    e.over = (mstate == 2);
    e.spd  = 5'(mspeed);
    e.sc   = 16'(mscore);
    return e;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  // Monitor: every clock the DUT presents a full output snapshot
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("obs_x", 64'(obs_x), 64'(e.x));
        check("obs_y", 64'(obs_y), 64'(e.y));
        check("obs_active", 64'(obs_active), 64'(e.act));
        check("collision", 64'(collision), 64'(e.coll));
        check("game_over", 64'(game_over), 64'(e.over));
        check("speed", 64'(speed), 64'(e.spd));
        check("score", 64'(score), 64'(e.sc));
      end
    end
  end

  // Stimulus: alternate phases where the player sits off-field (long games, speed ramp)
  // with phases of random player positions (frequent collisions and restarts)
  initial begin
    bit safe;
    rst = 1'b1; game_en = 1'b0; start = 1'b0; player_x = '0;
    for (int c = 0; c < NCYC && fails < 40; c++) begin
      @(negedge clk);
      safe    = ((c / 1500) % 2) == 1;
      rst     = (c < 2) || ($urandom_range(0, 2999) == 0);
      game_en = 1'($urandom_range(0, 1));
      if (c < 40)
        start = 1'b0;
      else if (mstate != 1)
        start = ($urandom_range(0, 9) == 0);
      else
        start = ($urandom_range(0, 49) == 0);
      if (safe)
        player_x = 10'd1000;
      else if (c % 40 == 0)
        player_x = 10'($urandom_range(0, 640));
      model_step(rst, game_en, start, int'(player_x));
      q.push_back(snap());
    end
    @(negedge clk);
    rst = 1'b0; game_en = 1'b0; start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
